// File: rtl/seg_pkg.sv
// Shared digit codes, FSM states and ASCII decode for seg_scroll_engine.
// Optional macro SEG_HEX_EN: 'A'-'F' / 'a'-'f' decode to hex codes 10-15.
package seg_pkg;

  typedef logic [4:0] digit_code_t;

  localparam digit_code_t CODE_BLANK = 5'h1F;
  localparam digit_code_t CODE_MINUS = 5'h10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FETCH = 3'd1,
    ST_LATCH = 3'd2,
    ST_HOLD  = 3'd3,
    ST_FLUSH = 3'd4
  } seg_state_e;

  function automatic digit_code_t ascii_to_code(input logic [7:0] ch);
    digit_code_t code;
    code = CODE_BLANK;
    if (ch >= 8'h30 && ch <= 8'h39) begin
      code = {1'b0, ch[3:0]};
    end else if (ch == 8'h2D) begin
      code = CODE_MINUS;
    end
`ifdef SEG_HEX_EN
    // Upper and lower case share the low nibble: 'A'/'a' = x1 -> 10.
    else if ((ch >= 8'h41 && ch <= 8'h46) || (ch >= 8'h61 && ch <= 8'h66)) begin
      code = {1'b0, ch[3:0]} + 5'd9;
    end
`endif
    return code;
  endfunction

endpackage

// File: rtl/seg_glyph.sv
// Combinational digit code to 7-segment pattern {g,f,e,d,c,b,a}.
// Unknown codes (including CODE_BLANK) show all segments off.
module seg_glyph
  import seg_pkg::*;
#(
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  digit_code_t code_i,
  output logic [6:0]  seg_o
);

  logic [6:0] pat;

  always_comb begin
    pat = 7'h00;
    case (code_i)
      5'd0:       pat = 7'h3F;
      5'd1:       pat = 7'h06;
      5'd2:       pat = 7'h5B;
      5'd3:       pat = 7'h4F;
      5'd4:       pat = 7'h66;
      5'd5:       pat = 7'h6D;
      5'd6:       pat = 7'h7D;
      5'd7:       pat = 7'h07;
      5'd8:       pat = 7'h7F;
      5'd9:       pat = 7'h6F;
      5'd10:      pat = 7'h77;
      5'd11:      pat = 7'h7C;
      5'd12:      pat = 7'h39;
      5'd13:      pat = 7'h5E;
      5'd14:      pat = 7'h79;
      5'd15:      pat = 7'h71;
      CODE_MINUS: pat = 7'h40;
      default:    pat = 7'h00;
    endcase
  end

  assign seg_o = (SEG_ACTIVE_LOW != 0) ? ~pat : pat;

endmodule

// File: rtl/seg_scroll_engine.sv
// Pops ASCII from a FIFO, decodes and scrolls digits right-to-left across an N-digit display.
// Optional macro SEG_HEX_EN (decoded in seg_pkg) adds hex letter glyphs.
module seg_scroll_engine
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 3,
  parameter int CLK_HZ         = 50_000_000,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_start,
  input  logic [1:0]              i_rate,
  input  logic [7:0]              i_fifo_data,
  input  logic                    i_fifo_empty,
  output logic                    o_fifo_rd,
  output logic [7*NUM_DIGITS-1:0] o_seg,
  output logic                    o_step,
  output logic                    o_busy
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int P0    = CLK_HZ;
  localparam int P1    = CLK_HZ >> 1;
  localparam int P2    = CLK_HZ >> 2;
  localparam logic [CNT_W-1:0] WRAP0 = CNT_W'((P0 > 0) ? P0 - 1 : 0);
  localparam logic [CNT_W-1:0] WRAP1 = CNT_W'((P1 > 0) ? P1 - 1 : 0);
  localparam logic [CNT_W-1:0] WRAP2 = CNT_W'((P2 > 0) ? P2 - 1 : 0);
  localparam logic [7*NUM_DIGITS-1:0] SEG_OFF = {7*NUM_DIGITS{SEG_ACTIVE_LOW != 0}};

  logic [CNT_W-1:0] cnt_q, cnt_d, wrap_at;
  logic [1:0]       rate_q;
  logic             run, rate_chg, tick;

  seg_state_e       state_q, state_d;
  digit_code_t      pend_q, pend_d;
  digit_code_t      dig_q [NUM_DIGITS];
  digit_code_t      dig_d [NUM_DIGITS];
  digit_code_t      shift_code;
  logic             rd, shift, win_blank_q, win_blank_d;
  logic [7*NUM_DIGITS-1:0] seg_q, glyph_w;

  // Step tick: counter clears whenever the rate selection changes.
  always_comb begin
    case (i_rate)
      2'b00:   wrap_at = WRAP0;
      2'b01:   wrap_at = WRAP1;
      2'b10:   wrap_at = WRAP2;
      default: wrap_at = '0;
    endcase
  end

  assign run      = i_start & (i_rate != 2'b11);
  assign rate_chg = (i_rate != rate_q);
  assign tick     = run & ~rate_chg & (cnt_q == wrap_at);

  always_comb begin
    cnt_d = cnt_q;
    if (rate_chg) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    win_blank_q = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (dig_q[k] != CODE_BLANK) win_blank_q = 1'b0;
    end
  end

  // FIFO handshake: o_fifo_rd pops one byte; that byte is valid on i_fifo_data
  // in the following cycle, which is always LATCH, so a started fetch is never lost.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    rd          = 1'b0;
    shift       = 1'b0;
    shift_code  = CODE_BLANK;
    win_blank_d = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) dig_d[k] = dig_q[k];

    case (state_q)
      ST_IDLE: if (i_start && !i_fifo_empty) state_d = ST_FETCH;
      ST_FETCH: begin
        if (i_start && !i_fifo_empty) begin
          rd      = 1'b1;
          state_d = ST_LATCH;
        end
      end
      ST_LATCH: begin
        pend_d  = ascii_to_code(i_fifo_data);
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (tick) begin
          shift      = 1'b1;
          shift_code = pend_q;
          state_d    = i_fifo_empty ? ST_FLUSH : ST_FETCH;
        end
      end
      ST_FLUSH: begin
        if (tick && !i_fifo_empty) state_d = ST_FETCH;
        else if (tick)             shift   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (shift) begin
      for (int k = NUM_DIGITS - 1; k > 0; k--) dig_d[k] = dig_q[k-1];
      dig_d[0] = shift_code;
    end

    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (dig_d[k] != CODE_BLANK) win_blank_d = 1'b0;
    end
    if (state_q == ST_FLUSH && state_d == ST_FLUSH && win_blank_d) state_d = ST_IDLE;
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_glyph
    seg_glyph #(
      .SEG_ACTIVE_LOW(SEG_ACTIVE_LOW)
    ) u_glyph (
      .code_i(dig_q[g]),
      .seg_o (glyph_w[7*g +: 7])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q   <= '0;
      rate_q  <= 2'b00;
      state_q <= ST_IDLE;
      pend_q  <= CODE_BLANK;
      seg_q   <= SEG_OFF;
      for (int k = 0; k < NUM_DIGITS; k++) dig_q[k] <= CODE_BLANK;
    end else begin
      cnt_q   <= cnt_d;
      rate_q  <= i_rate;
      state_q <= state_d;
      pend_q  <= pend_d;
      seg_q   <= glyph_w;
      for (int k = 0; k < NUM_DIGITS; k++) dig_q[k] <= dig_d[k];
    end
  end

  // Strobes are gated so that reset wins within the same cycle.
  assign o_fifo_rd = rd & ~reset;
  assign o_step    = shift & ~reset;
  assign o_seg     = seg_q;
  assign o_busy    = (state_q != ST_IDLE) | ~win_blank_q;

endmodule
